// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word and streams it one bit per cycle.
// Latency: first bit appears the cycle after the accepting edge; back-to-back words with zero gap.
// Backpressure: load is honoured only while ready is high; loads while busy are dropped.
module piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] p_in,
  input  logic             load,
  output logic             ready,
  output logic             s_out,
  output logic             s_valid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_reg;
  logic [CW-1:0]    cnt;
  logic             accept;

  // Load is taken only when the transmitter is idle or on its final bit.
  assign accept = load & ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and outputs, decoded only from registered state.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    s_valid   = 1'b0;
    last      = 1'b0;
    s_out     = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (load) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        s_valid = 1'b1;
        s_out   = MSB_FIRST ? sh_reg[WIDTH-1] : sh_reg[0];
        last    = (cnt == CNT_LAST);
        ready   = last;
        // On the final bit a fresh load keeps us in SHIFT with no gap.
        if (last && !load) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register and bit counter; the counter wraps to 0 after the last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_reg <= '0;
      cnt    <= '0;
    end else if (accept) begin
      sh_reg <= p_in;
      cnt    <= '0;
    end else if (state == SHIFT) begin
      sh_reg <= MSB_FIRST ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
      cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4, MSB first
  logic       rst_a, load_a;
  logic [3:0] p_a;
  logic       rdy_a, so_a, sv_a, la_a;
  // WIDTH=4, LSB first
  logic       rst_b, load_b;
  logic [3:0] p_b;
  logic       rdy_b, so_b, sv_b, la_b;
  // WIDTH=8, MSB first
  logic       rst_c, load_c;
  logic [7:0] p_c;
  logic       rdy_c, so_c, sv_c, la_c;

  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst_a), .p_in(p_a), .load(load_a),
    .ready(rdy_a), .s_out(so_a), .s_valid(sv_a), .last(la_a));
  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst_b), .p_in(p_b), .load(load_b),
    .ready(rdy_b), .s_out(so_b), .s_valid(sv_b), .last(la_b));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst_c), .p_in(p_c), .load(load_c),
    .ready(rdy_c), .s_out(so_c), .s_valid(sv_c), .last(la_c));

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] p;
    logic       so;
    logic       sv;
    logic       la;
    logic       rd;
  } vec_t;

  vec_t vecs[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %b, expected %b", name, idx, act, exp);
  endtask

  task automatic add(input logic r, input logic l, input logic [3:0] p,
                     input logic so, input logic sv, input logic la, input logic rd);
    vec_t v;
    v.rst = r; v.load = l; v.p = p; v.so = so; v.sv = sv; v.la = la; v.rd = rd;
    vecs.push_back(v);
  endtask

  initial begin
    logic exp_lsb [4];
    logic exp_w8  [8];
    exp_lsb = '{1'b1, 1'b1, 1'b0, 1'b1};
    exp_w8  = '{1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 0, 1'b1};

    rst_a = 1'b1; load_a = 1'b0; p_a = '0;
    rst_b = 1'b1; load_b = 1'b0; p_b = '0;
    rst_c = 1'b1; load_c = 1'b0; p_c = '0;

    // Each row: inputs before an edge, outputs expected just after it.
    //    rst load p_in     s_out s_valid last ready
    add(1, 0, 4'b0000,  0, 0, 0, 1);   // reset state
    // single word 1011
    add(0, 1, 4'b1011,  1, 1, 0, 0);
    add(0, 0, 4'b1111,  0, 1, 0, 0);   // p_in change must not matter
    add(0, 0, 4'b0000,  1, 1, 0, 0);
    add(0, 0, 4'b0000,  1, 1, 1, 1);
    add(0, 0, 4'b0000,  0, 0, 0, 1);   // back to IDLE
    // back-to-back 1100 then 0101
    add(0, 1, 4'b1100,  1, 1, 0, 0);
    add(0, 0, 4'b0101,  1, 1, 0, 0);
    add(0, 0, 4'b0101,  0, 1, 0, 0);
    add(0, 0, 4'b0101,  0, 1, 1, 1);
    add(0, 1, 4'b0101,  0, 1, 0, 0);
    add(0, 0, 4'b0000,  1, 1, 0, 0);
    add(0, 0, 4'b0000,  0, 1, 0, 0);
    add(0, 0, 4'b0000,  1, 1, 1, 1);
    add(0, 0, 4'b0000,  0, 0, 0, 1);
    // busy load ignored during bit 2 of 1011
    add(0, 1, 4'b1011,  1, 1, 0, 0);
    add(0, 0, 4'b1011,  0, 1, 0, 0);
    add(0, 1, 4'b0000,  1, 1, 0, 0);
    add(0, 0, 4'b0000,  1, 1, 1, 1);
    add(0, 0, 4'b0000,  0, 0, 0, 1);
    // reset mid-word of 1111, load held during reset to show priority
    add(0, 1, 4'b1111,  1, 1, 0, 0);
    add(0, 0, 4'b1111,  1, 1, 0, 0);
    add(1, 1, 4'b1111,  0, 0, 0, 1);
    add(0, 1, 4'b1001,  1, 1, 0, 0);   // load on first edge after reset
    add(0, 0, 4'b0110,  0, 1, 0, 0);
    add(0, 0, 4'b0110,  0, 1, 0, 0);
    add(0, 0, 4'b0110,  1, 1, 1, 1);
    add(0, 0, 4'b0110,  0, 0, 0, 1);
    add(0, 0, 4'b0110,  0, 0, 0, 1);   // stays idle with no load

    foreach (vecs[i]) begin
      rst_a = vecs[i].rst; load_a = vecs[i].load; p_a = vecs[i].p;
      @(posedge clk); #1;
      check("s_out",   i, so_a,  vecs[i].so);
      check("s_valid", i, sv_a,  vecs[i].sv);
      check("last",    i, la_a,  vecs[i].la);
      check("ready",   i, rdy_a, vecs[i].rd);
    end
    load_a = 1'b0;

    // LSB-first, 1011 -> 1,1,0,1
    @(posedge clk); #1;
    check("lsb_rst_ready", 0, rdy_b, 1'b1);
    check("lsb_rst_valid", 0, sv_b, 1'b0);
    rst_b = 1'b0; load_b = 1'b1; p_b = 4'b1011;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      load_b = 1'b0; p_b = 4'b0000;
      check("lsb_s_out",   k, so_b, exp_lsb[k]);
      check("lsb_s_valid", k, sv_b, 1'b1);
      check("lsb_last",    k, la_b, (k == 3));
    end
    @(posedge clk); #1;
    check("lsb_end_valid", 4, sv_b, 1'b0);
    check("lsb_end_ready", 4, rdy_b, 1'b1);

    // WIDTH=8, A5 -> 1,0,1,0,0,1,0,1
    rst_c = 1'b0; load_c = 1'b1; p_c = 8'hA5;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      load_c = 1'b0; p_c = 8'h00;
      check("w8_s_out", k, so_c, exp_w8[k]);
      check("w8_s_valid", k, sv_c, 1'b1);
      check("w8_last", k, la_c, (k == 7));
      check("w8_ready", k, rdy_c, (k == 7));
    end
    @(posedge clk); #1;
    check("w8_end_valid", 8, sv_c, 1'b0);
    check("w8_end_s_out", 8, so_c, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning the number of bits per parallel word (WIDTH >= 2).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk.
REQ-005 The block SHALL have port p_in  input  WIDTH  parallel word to transmit.
REQ-006 The block SHALL have port load  input  1  request to capture p_in.
REQ-007 The block SHALL have port ready  output  1  high when a load is accepted on this edge.
REQ-008 The block SHALL have port s_out  output  1  serial data bit.
REQ-009 The block SHALL have port s_valid  output  1  high while s_out carries a word bit.
REQ-010 The block SHALL have port last  output  1  high while s_out carries the final bit of a word.

Function
REQ-011 The FSM SHALL have exactly two states: IDLE and SHIFT.
REQ-012 In IDLE, ready SHALL be 1, and s_valid, last and s_out SHALL be 0.
REQ-013 A load is accepted on a rising edge where load=1 and ready=1; p_in SHALL be captured into the shift register, the bit counter cleared to 0, and the state SHALL go to SHIFT.
REQ-014 When load=1 and ready=0, load SHALL be ignored; there SHALL be no capture and no state change.
REQ-015 In SHIFT, s_valid SHALL be 1 and s_out SHALL present bit k of the captured word in the k-th cycle after acceptance (k = 0..WIDTH-1), in MSB_FIRST order; first bit appears in the cycle immediately after the accepting edge (latency 1 cycle).
REQ-016 Counter width SHALL be clog2(WIDTH) bits; it SHALL increment by 1 per SHIFT cycle and never exceed WIDTH-1.
REQ-017 last SHALL be 1 only in the SHIFT cycle where counter = WIDTH-1.
REQ-018 ready SHALL equal (state=IDLE) OR (state=SHIFT AND last=1).
REQ-019 At the edge ending the last cycle, load=1 SHALL capture the new word, clear the counter, and remain in SHIFT, with zero idle gap between words.
REQ-020 At the edge ending the last cycle, load=0 SHALL return the FSM to IDLE.
REQ-021 p_in changes after acceptance SHALL NOT affect the word in transmission.
REQ-022 All outputs SHALL be registered or decoded only from registered state; there SHALL be no combinational path from load or p_in to any output.

Reset
REQ-023 On a rising edge with rst=1, state SHALL become IDLE, the counter and shift register SHALL be cleared to 0, and in the next cycle s_out=0, s_valid=0, last=0, ready=1.
REQ-024 rst SHALL take priority over load, and a word in progress SHALL be abandoned with no further bits emitted.
REQ-025 After rst deasserts, a load on the first edge SHALL be accepted normally.

Verification (WIDTH=4 unless stated)
REQ-026 Scenario single word: MSB_FIRST=1, load p_in=4'b1011 for one edge -> s_out 1,0,1,1 with s_valid=1 on the next 4 cycles, last=1 only on the 4th, then IDLE with ready=1.
REQ-027 Scenario back-to-back: load 4'b1100, then hold load=1 with p_in=4'b0101 during the last cycle -> s_out 1,1,0,0,0,1,0,1 with s_valid continuously 1 for 8 cycles and last on cycles 4 and 8.
REQ-028 Scenario busy load: during bit 2 of 4'b1011, pulse load with p_in=4'b0000 -> stream unchanged at 1,0,1,1; FSM returns to IDLE after the word.
REQ-029 Scenario reset mid-word: assert rst after bit 1 of 4'b1111 -> next cycle s_valid=0, s_out=0, ready=1; a subsequent load of 4'b1001 streams 1,0,0,1.
REQ-030 Scenario LSB-first: MSB_FIRST=0, load 4'b1011 -> s_out 1,1,0,1, last on the 4th.
REQ-031 Scenario WIDTH=8: load 8'hA5 with MSB_FIRST=1 -> s_out 1,0,1,0,0,1,0,1, last on the 8th.
